// File: rtl/cacheline_arbiter.sv
// Two-way cacheline memory arbiter: icache and dcache share one 256-bit pmem port.
// Optional ARB_ROUND_ROBIN_EN: ties alternate between requesters instead of dcache priority.
module cacheline_arbiter #(
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state_r, state_nx;
  logic              pmem_read_nx, pmem_write_nx;
  logic [ADDR_W-1:0] pmem_addr_nx;
  logic [LINE_W-1:0] pmem_wdata_nx;
  logic [LINE_W-1:0] i_rdata_nx, d_rdata_nx;
  logic              i_resp_nx, d_resp_nx;
  logic              d_req_s, grant_i_s, grant_d_s;
  logic              unused_s;

  // Address offset bits are replaced by zeros on the memory side.
  assign unused_s = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;
  logic rr_last_r;

  // Remembers which requester received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= DCACHE;
    end else if (state_r == IDLE && grant_i_s) begin
      rr_last_r <= ICACHE;
    end else if (state_r == IDLE && grant_d_s) begin
      rr_last_r <= DCACHE;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end
`endif

  // Grant selection among the requests seen in IDLE.
  always_comb begin
    d_req_s = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
    grant_i_s = i_read & (~d_req_s | (rr_last_r == DCACHE));
`else
    grant_i_s = i_read & ~d_req_s;
`endif
    grant_d_s = d_req_s & ~grant_i_s;
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nx      = state_r;
    pmem_read_nx  = pmem_read;
    pmem_write_nx = pmem_write;
    pmem_addr_nx  = pmem_addr;
    pmem_wdata_nx = pmem_wdata;
    i_rdata_nx    = i_rdata;
    d_rdata_nx    = d_rdata;
    i_resp_nx     = 1'b0;
    d_resp_nx     = 1'b0;
    case (state_r)
      IDLE: begin
        pmem_wdata_nx = d_wdata;
        if (grant_d_s) begin
          state_nx      = D_BUSY;
          pmem_addr_nx  = {d_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          pmem_read_nx  = d_read & ~d_write;
          pmem_write_nx = d_write;
        end else if (grant_i_s) begin
          state_nx      = I_BUSY;
          pmem_addr_nx  = {i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          pmem_read_nx  = 1'b1;
          pmem_write_nx = 1'b0;
        end else begin
          state_nx      = IDLE;
          pmem_wdata_nx = pmem_wdata;
        end
      end
      I_BUSY: begin
        if (pmem_resp) begin
          state_nx      = RESP;
          pmem_read_nx  = 1'b0;
          pmem_write_nx = 1'b0;
          i_rdata_nx    = pmem_rdata;
          i_resp_nx     = 1'b1;
        end else begin
          state_nx = I_BUSY;
        end
      end
      D_BUSY: begin
        if (pmem_resp) begin
          state_nx      = RESP;
          pmem_read_nx  = 1'b0;
          pmem_write_nx = 1'b0;
          d_resp_nx     = 1'b1;
          // A writeback leaves the dcache read line untouched.
          if (!pmem_write) begin
            d_rdata_nx = pmem_rdata;
          end else begin
            d_rdata_nx = d_rdata;
          end
        end else begin
          state_nx = D_BUSY;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx      = IDLE;
        pmem_read_nx  = 1'b0;
        pmem_write_nx = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= {ADDR_W{1'b0}};
      pmem_wdata <= {LINE_W{1'b0}};
      i_rdata    <= {LINE_W{1'b0}};
      d_rdata    <= {LINE_W{1'b0}};
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      pmem_read  <= pmem_read_nx;
      pmem_write <= pmem_write_nx;
      pmem_addr  <= pmem_addr_nx;
      pmem_wdata <= pmem_wdata_nx;
      i_rdata    <= i_rdata_nx;
      d_rdata    <= d_rdata_nx;
      i_resp     <= i_resp_nx;
      d_resp     <= d_resp_nx;
    end
  end

endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares the single physical cacheline memory port (magic_memory_dp / ParamMemory side, 256-bit lines) between the instruction cache and the data cache.
- Sits between both caches and the pmem interface of the core top level.
- Grants one requester at a time and holds the grant until its transaction completes.
- Forwards responses back only to the granted cache. Fully registered toward memory.

Parameters:
- LINE_W, 256, cacheline width in bits (data buses).
- ADDR_W, 32, byte address width.
- OFFSET_W, 5, log2(LINE_W/8); low address bits forced to zero on pmem_addr.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  icache line read request, held until i_resp
- i_addr  in  ADDR_W  icache request address
- i_rdata  out  LINE_W  icache read line
- i_resp  out  1  icache completion pulse, 1 cycle
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line writeback request, held until d_resp
- d_addr  in  ADDR_W  dcache request address
- d_wdata  in  LINE_W  dcache writeback line
- d_rdata  out  LINE_W  dcache read line
- d_resp  out  1  dcache completion pulse, 1 cycle
- pmem_read  out  1  physical memory read strobe
- pmem_write  out  1  physical memory write strobe
- pmem_addr  out  ADDR_W  line-aligned physical address
- pmem_wdata  out  LINE_W  physical write line
- pmem_rdata  in  LINE_W  physical read line, valid with pmem_resp
- pmem_resp  in  1  physical memory completion

Behaviour:
- States: IDLE, I_BUSY, D_BUSY, RESP. Reset, async on rst_n low:
  - state=IDLE
  - all outputs 0: pmem_*, i_resp, d_resp, i_rdata, d_rdata
  - rr_last=DCACHE
- IDLE, arbitration:
  - dcache request = d_read|d_write.
  - Only one requester active: grant it.
  - Both active: dcache wins (fixed priority).
  - On grant, register on the same edge:
    - pmem_addr = {addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}
    - pmem_read = d_read&~d_write (dcache) or 1 (icache)
    - pmem_write = d_write (dcache only)
    - pmem_wdata = d_wdata
  - Strobe visible the cycle after the request is first seen (1-cycle grant latency).
- d_read and d_write both high is illegal. Treat as a write; no read is issued.
- I_BUSY/D_BUSY:
  - Hold pmem strobe, address and wdata stable; ignore new requests and changes on requester inputs.
  - When pmem_resp=1:
    - Drop the strobes on the next edge.
    - Latch pmem_rdata into the granted requester's rdata (not on writes; rdata holds its previous value).
    - Pulse the granted requester's resp for exactly one cycle.
    - Go to RESP.
- RESP:
  - resp high this cycle only; strobes low.
  - Next state is IDLE unconditionally.
  - Requester deasserts its request on the edge ending RESP, so no double-serve.
- Total latency: pmem_resp in cycle M gives requester resp in cycle M+1. Minimum back-to-back spacing is 1 idle cycle (RESP→IDLE→new grant).
- pmem_resp while IDLE or RESP: ignored, no resp generated.
- Non-granted requester is never given a resp; its request stays pending and is served next time IDLE is reached.
- i_rdata/d_rdata change only on their own completing reads.
- rst_n low mid-transaction: immediate return to IDLE, strobes drop asynchronously, the in-flight transaction is abandoned (no resp).

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the requester not granted last.
  - rr_last updates on each grant; reset value DCACHE, so icache wins the first tie.
  - A single requester is still granted immediately.
- Undefined: fixed dcache priority; rr_last is not implemented.

Test Plan:
- Reset, then i_read=1, i_addr=0x0000_1234 → pmem_read=1 with pmem_addr=0x0000_1220 next cycle. pmem_resp with pmem_rdata=0xAA..AA → i_resp=1 one cycle later with i_rdata=0xAA..AA; d_resp stays 0.
- d_write=1, d_addr=0x8000_0040, d_wdata=0x55..55 → pmem_write=1, pmem_wdata=0x55..55. pmem_resp → d_resp=1 for one cycle; d_rdata unchanged.
- i_read and d_read asserted in the same cycle → dcache served first. After d_resp, i_read still high → icache granted 2 cycles after d_resp. With ARB_ROUND_ROBIN_EN, icache is served first.
- Toggle d_addr and d_wdata during D_BUSY with pmem_resp delayed 20 cycles → pmem_addr/pmem_wdata hold the latched values for all 20 cycles.
- Spurious pmem_resp in IDLE → no i_resp/d_resp, state stays IDLE.
- rst_n low for 1 cycle during I_BUSY → pmem_read drops immediately, no i_resp. A fresh i_read after reset completes normally.
